// File: rtl/step_clock_gen.sv
// CPU advance strobe generator: debounced single-step pushbutton or a
// free-running divided tick in run mode, delivered as a one-cycle enable
// synchronous to clk (no derived clocks).
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | button released and stable
// PRESS_WAIT   | button seen high, waiting for DB_LIMIT stable cycles
// PRESSED      | press accepted, button held
// RELEASE_WAIT | button seen low, waiting for DB_LIMIT stable cycles
module step_clock_gen #(
   parameter int DB_W      = 20,
   parameter int DB_LIMIT  = 1000000,
   parameter int DIV_W     = 26,
   parameter int DIV_LIMIT = 50000000,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_raw,
   input  logic             mode_sw,
   input  logic             halt,
   output logic             cpu_en,
   output logic             step_pulse,
   output logic             btn_level,
   output logic             run_mode,
   output logic [CNT_W-1:0] step_count
);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_LIMIT - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_LIMIT - 1);

   logic              btn_meta;
   logic              btn_s;
   logic              mode_meta;
   logic [1:0]        state;
   logic [DB_W-1:0]   db_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic              run_tick;

   // Two-flop synchronizers for the asynchronous button and mode switch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_meta  <= 1'b0;
         btn_s     <= 1'b0;
         mode_meta <= 1'b0;
         run_mode  <= 1'b0;
      end else begin
         btn_meta  <= btn_raw;
         btn_s     <= btn_meta;
         mode_meta <= mode_sw;
         run_mode  <= mode_meta;
      end
   end

   // Debounce FSM; step_pulse fires on the cycle the press is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         db_cnt     <= '0;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (btn_s) begin
                  state  <= PRESS_WAIT;
                  db_cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!btn_s) begin
                  state <= IDLE;
               end else if (db_cnt == DB_LAST) begin
                  state      <= PRESSED;
                  step_pulse <= 1'b1;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
            PRESSED: begin
               if (!btn_s) begin
                  state  <= RELEASE_WAIT;
                  db_cnt <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (btn_s) begin
                  state <= PRESSED;
               end else if (db_cnt == DB_LAST) begin
                  state <= IDLE;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The debounced level is a decode of the registered state, so it is glitch-free.
   assign btn_level = (state == PRESSED) || (state == RELEASE_WAIT);

   // The tick only exists while the divider is actually allowed to run.
   assign run_tick = run_mode && !halt && (div_cnt == DIV_LAST);

   // Run-mode divider; leaving run mode or halting restarts a full period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (!run_mode || halt) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Strobe select; a strobe coinciding with halt is dropped, not deferred.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_en <= 1'b0;
      end else begin
         cpu_en <= !halt && (run_mode ? run_tick : step_pulse);
      end
   end

   // Count issued strobes, wrapping naturally at the counter width.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_count <= '0;
      end else if (cpu_en) begin
         step_count <= step_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen with short debounce/divide limits. Expected strobe
// cycles are queued when stimulus is applied and matched by a negedge monitor.
module tb_step_clock_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_raw;
   logic       mode_sw;
   logic       halt;
   logic       cpu_en;
   logic       step_pulse;
   logic       btn_level;
   logic       run_mode;
   logic [3:0] step_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int e_cyc;
   int en_q[$];
   int sp_q[$];
   logic [3:0] exp_cnt;

   step_clock_gen #(
      .DB_W(4), .DB_LIMIT(4), .DIV_W(4), .DIV_LIMIT(5), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw), .mode_sw(mode_sw),
      .halt(halt), .cpu_en(cpu_en), .step_pulse(step_pulse),
      .btn_level(btn_level), .run_mode(run_mode), .step_count(step_count)
   );

   always #5 clk = ~clk;

   // Edge counter: after edge k (sampled later in the cycle) cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every observed strobe must match the next queued cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (cpu_en === 1'b1) begin
            checks++;
            if (en_q.size() == 0) begin
               errors++;
               $display("FAIL cpu_en_unexpected at cycle %0d got 1 want 0", cyc);
            end else begin
               e_cyc = en_q.pop_front();
               if (cyc != e_cyc) begin
                  errors++;
                  $display("FAIL cpu_en_timing got cycle %0d want cycle %0d", cyc, e_cyc);
               end
            end
         end
         if (step_pulse === 1'b1) begin
            checks++;
            if (sp_q.size() == 0) begin
               errors++;
               $display("FAIL step_pulse_unexpected at cycle %0d got 1 want 0", cyc);
            end else begin
               e_cyc = sp_q.pop_front();
               if (cyc != e_cyc) begin
                  errors++;
                  $display("FAIL step_pulse_timing got cycle %0d want cycle %0d", cyc, e_cyc);
               end
            end
         end
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int r0;
      reset = 1'b1; btn_raw = 1'b1; mode_sw = 1'b1; halt = 1'b0;
      exp_cnt = 4'd0;
      cyc_wait(3);
      checks++;
      if ({cpu_en, step_pulse, btn_level, run_mode, step_count} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got %b want 00000000",
                  {cpu_en, step_pulse, btn_level, run_mode, step_count});
      end
      reset = 1'b0;
      r0 = cyc;
      en_q.push_back(r0 + 7);
      sp_q.push_back(r0 + 7);
      cyc_wait(8);
      mode_sw = 1'b0; btn_raw = 1'b0;
      cyc_wait(12);
      exp_cnt = exp_cnt + 4'd1;
      checks++;
      if (step_count !== exp_cnt) begin
         errors++;
         $display("FAIL reset_step_count got %0d want %0d", step_count, exp_cnt);
      end
      checks++;
      if (en_q.size() != 0 || sp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_drain got en %0d sp %0d pending want 0 0", en_q.size(), sp_q.size());
      end
   endtask

   task automatic test_single_step();
      int c;
      mode_sw = 1'b0; btn_raw = 1'b1;
      c = cyc;
      sp_q.push_back(c + 7);
      en_q.push_back(c + 8);
      cyc_wait(20);
      checks++;
      if (btn_level !== 1'b1) begin
         errors++;
         $display("FAIL step_btn_level_held got %b want 1", btn_level);
      end
      exp_cnt = exp_cnt + 4'd1;
      checks++;
      if (step_count !== exp_cnt) begin
         errors++;
         $display("FAIL step_count got %0d want %0d", step_count, exp_cnt);
      end
      btn_raw = 1'b0;
      cyc_wait(10);
      checks++;
      if (btn_level !== 1'b0) begin
         errors++;
         $display("FAIL step_btn_level_released got %b want 0", btn_level);
      end
      checks++;
      if (en_q.size() != 0 || sp_q.size() != 0) begin
         errors++;
         $display("FAIL step_drain got en %0d sp %0d pending want 0 0", en_q.size(), sp_q.size());
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 20; i++) begin
         btn_raw = ((i % 4) < 2);
         cyc_wait(1);
         checks++;
         if (btn_level !== 1'b0) begin
            errors++;
            $display("FAIL bounce_btn_level step %0d got %b want 0", i, btn_level);
         end
      end
      btn_raw = 1'b0;
      cyc_wait(8);
      checks++;
      if (step_count !== exp_cnt) begin
         errors++;
         $display("FAIL bounce_step_count got %0d want %0d", step_count, exp_cnt);
      end
   endtask

   task automatic test_run_halt();
      int c;
      int h0;
      mode_sw = 1'b1;
      c = cyc;
      for (int k = 0; k < 6; k++) en_q.push_back(c + 7 + 5 * k);
      cyc_wait(36);
      halt = 1'b1;
      cyc_wait(10);
      halt = 1'b0;
      h0 = cyc;
      en_q.push_back(h0 + 5);
      en_q.push_back(h0 + 10);
      cyc_wait(12);
      mode_sw = 1'b0;
      cyc_wait(8);
      exp_cnt = exp_cnt + 4'd8;
      checks++;
      if (step_count !== exp_cnt) begin
         errors++;
         $display("FAIL run_halt_step_count got %0d want %0d", step_count, exp_cnt);
      end
      checks++;
      if (en_q.size() != 0) begin
         errors++;
         $display("FAIL run_halt_drain got %0d pending want 0", en_q.size());
      end
   endtask

   task automatic test_run_press();
      int c;
      mode_sw = 1'b1; btn_raw = 1'b0;
      c = cyc;
      for (int k = 0; k < 4; k++) en_q.push_back(c + 7 + 5 * k);
      cyc_wait(8);
      checks++;
      if (run_mode !== 1'b1) begin
         errors++;
         $display("FAIL run_press_run_mode got %b want 1", run_mode);
      end
      btn_raw = 1'b1;
      sp_q.push_back(c + 15);
      cyc_wait(15);
      mode_sw = 1'b0; btn_raw = 1'b0;
      cyc_wait(12);
      exp_cnt = exp_cnt + 4'd4;
      checks++;
      if (step_count !== exp_cnt) begin
         errors++;
         $display("FAIL run_press_step_count got %0d want %0d", step_count, exp_cnt);
      end
      checks++;
      if (en_q.size() != 0 || sp_q.size() != 0) begin
         errors++;
         $display("FAIL run_press_drain got en %0d sp %0d pending want 0 0", en_q.size(), sp_q.size());
      end
   endtask

   task automatic test_wrap();
      int r0;
      reset = 1'b1;
      cyc_wait(2);
      reset = 1'b0; mode_sw = 1'b1;
      r0 = cyc;
      for (int k = 0; k < 17; k++) en_q.push_back(r0 + 7 + 5 * k);
      for (int i = 0; i < 88; i++) begin
         cyc_wait(1);
         if (cyc == r0 + 78) begin
            checks++;
            if (step_count !== 4'd15) begin
               errors++;
               $display("FAIL wrap_at_15 got %0d want 15", step_count);
            end
         end
         if (cyc == r0 + 83) begin
            checks++;
            if (step_count !== 4'd0) begin
               errors++;
               $display("FAIL wrap_to_0 got %0d want 0", step_count);
            end
         end
         if (cyc == r0 + 88) begin
            checks++;
            if (step_count !== 4'd1) begin
               errors++;
               $display("FAIL wrap_to_1 got %0d want 1", step_count);
            end
         end
      end
      mode_sw = 1'b0;
      cyc_wait(8);
      checks++;
      if (en_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_drain got %0d pending want 0", en_q.size());
      end
   endtask

   task automatic test_reset_mid_press();
      btn_raw = 1'b1;
      cyc_wait(5);
      reset = 1'b1;
      #1;
      checks++;
      if ({cpu_en, step_pulse, btn_level, run_mode, step_count} !== 8'h00) begin
         errors++;
         $display("FAIL midreset_outputs got %b want 00000000",
                  {cpu_en, step_pulse, btn_level, run_mode, step_count});
      end
      cyc_wait(2);
      reset = 1'b0;
      cyc_wait(2);
      btn_raw = 1'b0;
      cyc_wait(10);
      checks++;
      if (btn_level !== 1'b0 || step_count !== 4'd0) begin
         errors++;
         $display("FAIL midreset_after got level %b count %0d want 0 0", btn_level, step_count);
      end
      checks++;
      if (sp_q.size() != 0 || en_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_drain got en %0d sp %0d pending want 0 0", en_q.size(), sp_q.size());
      end
   endtask

   initial begin
      reset = 1'b1; btn_raw = 1'b0; mode_sw = 1'b0; halt = 1'b0;
      test_reset();
      test_single_step();
      test_bounce();
      test_run_halt();
      test_run_press();
      test_wrap();
      test_reset_mid_press();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
